// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and SOCD-filter raw button bits into a
// registered active-high key vector with a one-clk change pulse.
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter bit SOCD_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ce,
  input  logic [8:0] raw_keys,
  output logic [8:0] keys_active,
  output logic       key_event
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
  logic [8:0] sync_a, sync_q, stable, stable_nxt, filtered;
  logic [CW-1:0] cnt [9];
  logic [CW-1:0] cnt_nxt [9];
  // A bit flips on the tick that would make its disagreement run reach DEBOUNCE_TICKS.
  always_comb begin
    stable_nxt = stable;
    for (int k = 0; k < 9; k++) begin
      cnt_nxt[k] = cnt[k];
      if (clk_ce) begin
        stable_nxt[k] = (sync_q[k] != stable[k] && cnt[k] == LAST) ? sync_q[k] : stable[k];
        cnt_nxt[k] = (sync_q[k] == stable[k] || cnt[k] == LAST) ? '0 : cnt[k] + 1'b1;
      end
    end
  end
  assign filtered = stable_nxt & ~{2'b00,
                                   {2{SOCD_MODE && stable_nxt[5] && stable_nxt[6]}},
                                   {2{SOCD_MODE && stable_nxt[3] && stable_nxt[4]}},
                                   3'b000};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_q <= '0;
      stable <= '0;
      keys_active <= '0;
      key_event <= 1'b0;
      for (int k = 0; k < 9; k++) cnt[k] <= '0;
    end else begin
      sync_a <= raw_keys;
      sync_q <= sync_a;
      stable <= stable_nxt;
      keys_active <= filtered;
      key_event <= filtered != keys_active;
      for (int k = 0; k < 9; k++) cnt[k] <= cnt_nxt[k];
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce; expected key vectors are
// queued when stimulus is driven and popped on every key_event pulse.
module tb_key_debounce;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_ce = 1'b0;
  logic [8:0] raw_keys = '0;
  logic [8:0] ka, ka0, ka1;
  logic ev, ev0, ev1;
  int checks = 0;
  int failures = 0;
  int ev_cnt = 0;
  int ev0_cnt = 0;
  int ev1_cnt = 0;
  logic [8:0] exp_q[$];

  key_debounce dut (.clk(clk), .reset(reset), .clk_ce(clk_ce), .raw_keys(raw_keys),
                    .keys_active(ka), .key_event(ev));
  key_debounce #(.DEBOUNCE_TICKS(4), .SOCD_MODE(1'b0)) dut0 (.clk(clk), .reset(reset),
                    .clk_ce(clk_ce), .raw_keys(raw_keys), .keys_active(ka0), .key_event(ev0));
  key_debounce #(.DEBOUNCE_TICKS(1), .SOCD_MODE(1'b1)) dut1 (.clk(clk), .reset(reset),
                    .clk_ce(clk_ce), .raw_keys(raw_keys), .keys_active(ka1), .key_event(ev1));

  always #5 clk = ~clk;

  function automatic logic [8:0] socd(input logic [8:0] v, input bit m);
    logic [8:0] r;
    r = v;
    if (m && v[3] && v[4]) r[4:3] = 2'b00;
    if (m && v[5] && v[6]) r[6:5] = 2'b00;
    return r;
  endfunction

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ev0) ev0_cnt++;
    if (!reset && ev1) ev1_cnt++;
    if (!reset && ev) begin
      ev_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: keys_active=%h with nothing expected", ka);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (ka !== e) begin
          failures++;
          $display("FAIL scoreboard: keys_active=%h want %h", ka, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      clk_ce = 1'b1;
      @(negedge clk);
      clk_ce = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int e0;
    reset = 1'b1;
    raw_keys = 9'h1FF;
    for (int k = 0; k < 8; k++) begin
      clk_ce = (k % 4 == 0);
      @(negedge clk);
      checks++;
      if (ka !== 9'h000 || ev !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: keys_active=%h key_event=%b want 000/0", ka, ev);
      end
    end
    clk_ce = 1'b0;
    reset = 1'b0;
    e0 = ev_cnt;
    exp_q.push_back(socd(9'h1FF, 1'b1));
    step(2);
    ticks(3);
    checks++;
    if (ka !== 9'h000) begin
      failures++;
      $display("FAIL reset_early: keys_active=%h want 000", ka);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h187 || ka0 !== 9'h1FF || ev_cnt != e0 + 1) begin
      failures++;
      $display("FAIL reset_all: keys_active=%h socd0=%h events=%0d want 187/1FF/1", ka, ka0, ev_cnt - e0);
    end
    raw_keys = 9'h000;
    exp_q.push_back(9'h000);
    step(2);
    ticks(4);
    checks++;
    if (ka !== 9'h000 || ka0 !== 9'h000) begin
      failures++;
      $display("FAIL reset_release_all: keys_active=%h socd0=%h want 000/000", ka, ka0);
    end
  endtask

  task automatic test_press_a;
    int e0, e1;
    e0 = ev_cnt;
    e1 = ev1_cnt;
    raw_keys = 9'h001;
    exp_q.push_back(9'h001);
    step(2);
    ticks(1);
    checks++;
    if (ka1 !== 9'h001 || ev1_cnt != e1 + 1 || ka !== 9'h000) begin
      failures++;
      $display("FAIL one_tick: ticks1=%h events1=%0d ticks4=%h want 001/1/000", ka1, ev1_cnt - e1, ka);
    end
    ticks(2);
    checks++;
    if (ka !== 9'h000 || ev_cnt != e0) begin
      failures++;
      $display("FAIL press_early: keys_active=%h events=%0d want 000/0", ka, ev_cnt - e0);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h001 || ev_cnt != e0 + 1) begin
      failures++;
      $display("FAIL press_a: keys_active=%h events=%0d want 001/1", ka, ev_cnt - e0);
    end
    raw_keys = 9'h000;
    exp_q.push_back(9'h000);
    step(2);
    ticks(3);
    checks++;
    if (ka !== 9'h001) begin
      failures++;
      $display("FAIL release_early: keys_active=%h want 001", ka);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h000 || ev_cnt != e0 + 2) begin
      failures++;
      $display("FAIL release_a: keys_active=%h events=%0d want 000/2", ka, ev_cnt - e0);
    end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = ev_cnt;
    raw_keys = 9'h002;
    step(2);
    ticks(3);
    raw_keys = 9'h000;
    step(2);
    ticks(1);
    checks++;
    if (ka !== 9'h000 || ev_cnt != e0) begin
      failures++;
      $display("FAIL glitch_reject: keys_active=%h events=%0d want 000/0", ka, ev_cnt - e0);
    end
    raw_keys = 9'h002;
    exp_q.push_back(9'h002);
    step(2);
    ticks(3);
    checks++;
    if (ka !== 9'h000) begin
      failures++;
      $display("FAIL glitch_restart: keys_active=%h want 000", ka);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h002 || ev_cnt != e0 + 1) begin
      failures++;
      $display("FAIL glitch_run: keys_active=%h events=%0d want 002/1", ka, ev_cnt - e0);
    end
    raw_keys = 9'h000;
    exp_q.push_back(9'h000);
    step(2);
    ticks(4);
  endtask

  task automatic test_socd;
    logic [8:0] pat [4];
    int e0, f0;
    pat[0] = 9'h008;
    pat[1] = 9'h018;
    pat[2] = 9'h010;
    pat[3] = 9'h000;
    for (int p = 0; p < 4; p++) begin
      e0 = ev_cnt;
      raw_keys = pat[p];
      exp_q.push_back(socd(pat[p], 1'b1));
      step(2);
      ticks(4);
      checks++;
      if (ka !== socd(pat[p], 1'b1) || ka0 !== pat[p] || ev_cnt != e0 + 1) begin
        failures++;
        $display("FAIL socd_%0d: keys_active=%h socd0=%h events=%0d want %h/%h/1",
                 p, ka, ka0, ev_cnt - e0, socd(pat[p], 1'b1), pat[p]);
      end
    end
    // Both directions together: stable changes but the filtered output does not.
    e0 = ev_cnt;
    f0 = ev0_cnt;
    raw_keys = 9'h060;
    step(2);
    ticks(4);
    raw_keys = 9'h000;
    step(2);
    ticks(4);
    checks++;
    if (ka !== 9'h000 || ev_cnt != e0 || ev0_cnt != f0 + 2) begin
      failures++;
      $display("FAIL socd_silent: keys_active=%h events=%0d events0=%0d want 000/0/2",
               ka, ev_cnt - e0, ev0_cnt - f0);
    end
  endtask

  task automatic test_ce_gating;
    raw_keys = 9'h080;
    exp_q.push_back(9'h080);
    clk_ce = 1'b0;
    step(100);
    checks++;
    if (ka !== 9'h000) begin
      failures++;
      $display("FAIL ce_hold: keys_active=%h want 000", ka);
    end
    ticks(3);
    checks++;
    if (ka !== 9'h000) begin
      failures++;
      $display("FAIL ce_early: keys_active=%h want 000", ka);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h080) begin
      failures++;
      $display("FAIL ce_power: keys_active=%h want 080", ka);
    end
    raw_keys = 9'h000;
    exp_q.push_back(9'h000);
    step(2);
    ticks(4);
  endtask

  task automatic test_reset_mid;
    raw_keys = 9'h001;
    exp_q.push_back(9'h001);
    step(2);
    ticks(4);
    raw_keys = 9'h101;
    step(2);
    ticks(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ka !== 9'h000 || ev !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: keys_active=%h key_event=%b want 000/0", ka, ev);
    end
    step(3);
    reset = 1'b0;
    exp_q.push_back(9'h101);
    step(2);
    ticks(3);
    checks++;
    if (ka !== 9'h000) begin
      failures++;
      $display("FAIL reset_partial: keys_active=%h want 000", ka);
    end
    ticks(1);
    checks++;
    if (ka !== 9'h101) begin
      failures++;
      $display("FAIL reset_shock: keys_active=%h want 101", ka);
    end
    raw_keys = 9'h000;
    exp_q.push_back(9'h000);
    step(2);
    ticks(4);
  endtask

  initial begin
    test_reset();
    test_press_a();
    test_glitch();
    test_socd();
    test_ce_gating();
    test_reset_mid();
    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d expected pulses never seen, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
